// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable clock dividers sharing one config port.
// Optional macro CLKDIV_SYNC_EN adds a 'sync' input that restarts all enabled channels in phase.
module clk_div_bank #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_in,
  input  logic           rst,
`ifdef CLKDIV_SYNC_EN
  input  logic           sync,
`endif
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  input  logic           cfg_en,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] active
);

  logic [NCH-1:0] pend_vld;

  // Out-of-range channel indices never match a slot, so they read as ready and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i) && pend_vld[i]) cfg_ready = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DW-1:0] div_q, div_d, cnt_q, cnt_d, pdiv_q, pdiv_d;
    logic          en_q, en_d, pen_q, pen_d, pvld_q, pvld_d;
    logic          clk_q, clk_d, tick_q, tick_d, prime_q, prime_d;
    logic [DW-1:0] per, cnt_inc;
    logic [DW:0]   half;
    logic          wrap, wr;

    always_comb begin
      per     = (div_q < DW'(2)) ? DW'(2) : div_q;
      half    = ({1'b0, per} + (DW+1)'(1)) >> 1;
      wrap    = (cnt_q == per - DW'(1));
      cnt_inc = wrap ? '0 : cnt_q + DW'(1);
      wr      = cfg_valid && cfg_ready && (cfg_ch == CW'(gi));

      div_d   = div_q;
      cnt_d   = cnt_q;
      pdiv_d  = pdiv_q;
      en_d    = en_q;
      pen_d   = pen_q;
      pvld_d  = pvld_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      prime_d = prime_q;

      if (en_q) begin
        cnt_d  = cnt_inc;
        // prime_q keeps the output low until the first wrap after a (re)start,
        // so the first rising edge always coincides with a tick.
        clk_d  = ({1'b0, cnt_inc} < half) && (!prime_q || wrap);
        tick_d = wrap;
        if (wrap) begin
          prime_d = 1'b0;
          if (pvld_q) begin
            div_d  = pdiv_q;
            en_d   = pen_q;
            pvld_d = 1'b0;
            if (!pen_q) begin
              cnt_d  = '0;
              clk_d  = 1'b0;
              tick_d = 1'b0;
            end
          end
        end
      end else begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b0;
        if (pvld_q) begin
          div_d   = pdiv_q;
          en_d    = pen_q;
          pvld_d  = 1'b0;
          prime_d = 1'b1;
        end
      end

`ifdef CLKDIV_SYNC_EN
      if (sync && en_q) begin
        if (pvld_q) begin
          div_d  = pdiv_q;
          en_d   = pen_q;
          pvld_d = 1'b0;
        end
        cnt_d   = '0;
        clk_d   = 1'b1;
        tick_d  = 1'b1;
        prime_d = 1'b0;
      end
`endif

      // A slot is only writable when empty, so this never collides with an apply.
      if (wr) begin
        pdiv_d = cfg_div;
        pen_d  = cfg_en;
        pvld_d = 1'b1;
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst) begin
        div_q   <= DW'(2);
        cnt_q   <= '0;
        pdiv_q  <= '0;
        en_q    <= 1'b1;
        pen_q   <= 1'b0;
        pvld_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        prime_q <= 1'b1;
      end else begin
        div_q   <= div_d;
        cnt_q   <= cnt_d;
        pdiv_q  <= pdiv_d;
        en_q    <= en_d;
        pen_q   <= pen_d;
        pvld_q  <= pvld_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
        prime_q <= prime_d;
      end
    end

    assign pend_vld[gi] = pvld_q;
    assign clk_out[gi]  = clk_q;
    assign tick[gi]     = tick_q;
    assign active[gi]   = en_q;
  end

endmodule
